// File: rtl/cpu_pkg.sv
// Shared SimMIPS decode constants, instruction classes and the queued-entry layout.
// ID_RI_EXC_EN adds a reserved-instruction bit to each entry.
package cpu_pkg;

  typedef enum logic [3:0] {
    CLS_ALU      = 4'd0,
    CLS_SHIFT    = 4'd1,
    CLS_LOAD     = 4'd2,
    CLS_STORE    = 4'd3,
    CLS_BRANCH   = 4'd4,
    CLS_JUMPLINK = 4'd5,
    CLS_MDU      = 4'd6,
    CLS_COP0     = 4'd7,
    CLS_SYSCALL  = 4'd8,
    CLS_ERET     = 4'd9,
    CLS_INVALID  = 4'd15
  } cls_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] TAIL_SLL     = 6'h00;
  localparam logic [5:0] TAIL_SRL     = 6'h02;
  localparam logic [5:0] TAIL_SRA     = 6'h03;
  localparam logic [5:0] TAIL_SLLV    = 6'h04;
  localparam logic [5:0] TAIL_SRLV    = 6'h06;
  localparam logic [5:0] TAIL_SRAV    = 6'h07;
  localparam logic [5:0] TAIL_JR      = 6'h08;
  localparam logic [5:0] TAIL_JALR    = 6'h09;
  localparam logic [5:0] TAIL_MOVZ    = 6'h0A;
  localparam logic [5:0] TAIL_MOVN    = 6'h0B;
  localparam logic [5:0] TAIL_SYSCALL = 6'h0C;
  localparam logic [5:0] TAIL_MFHI    = 6'h10;
  localparam logic [5:0] TAIL_MTHI    = 6'h11;
  localparam logic [5:0] TAIL_MFLO    = 6'h12;
  localparam logic [5:0] TAIL_MTLO    = 6'h13;
  localparam logic [5:0] TAIL_MULT    = 6'h18;
  localparam logic [5:0] TAIL_MULTU   = 6'h19;
  localparam logic [5:0] TAIL_DIV     = 6'h1A;
  localparam logic [5:0] TAIL_DIVU    = 6'h1B;
  localparam logic [5:0] TAIL_ADD     = 6'h20;
  localparam logic [5:0] TAIL_ADDU    = 6'h21;
  localparam logic [5:0] TAIL_SUB     = 6'h22;
  localparam logic [5:0] TAIL_SUBU    = 6'h23;
  localparam logic [5:0] TAIL_AND     = 6'h24;
  localparam logic [5:0] TAIL_OR      = 6'h25;
  localparam logic [5:0] TAIL_XOR     = 6'h26;
  localparam logic [5:0] TAIL_NOR     = 6'h27;
  localparam logic [5:0] TAIL_SLT     = 6'h2A;
  localparam logic [5:0] TAIL_SLTU    = 6'h2B;
  localparam logic [5:0] TAIL_MUL     = 6'h02;
  localparam logic [5:0] TAIL_CLZ     = 6'h20;
  localparam logic [5:0] TAIL_CLO     = 6'h21;
  localparam logic [5:0] TAIL_TLBR    = 6'h01;
  localparam logic [5:0] TAIL_TLBWI   = 6'h02;
  localparam logic [5:0] TAIL_TLBWR   = 6'h06;
  localparam logic [5:0] TAIL_TLBP    = 6'h08;
  localparam logic [5:0] TAIL_ERET    = 6'h18;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [4:0] RS_MF = 5'h00;
  localparam logic [4:0] RS_MT = 5'h04;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    cls_e        cls;
    logic        regwr;
    logic [4:0]  regdst;
`ifdef ID_RI_EXC_EN
    logic        ri;
`endif
  } id_entry_t;

endpackage

// File: rtl/id_predecode.sv
// Combinational pre-decode of one instruction word into class, GPR write enable and destination.
// ID_RI_EXC_EN adds the reserved-instruction output ri_o.
module id_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output cls_e        cls_o,
  output logic        regwr_o,
`ifdef ID_RI_EXC_EN
  output logic        ri_o,
`endif
  output logic [4:0]  regdst_o
);

  logic [5:0] op, tail;
  logic [4:0] rs, rt, rd;
  logic       extra_wr;
  cls_e       cls;
  logic       unused_shamt;

  assign op   = instr_i[31:26];
  assign rs   = instr_i[25:21];
  assign rt   = instr_i[20:16];
  assign rd   = instr_i[15:11];
  assign tail = instr_i[5:0];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    cls      = CLS_INVALID;
    extra_wr = 1'b0;
    regdst_o = rd;
    case (op)
      OP_SPECIAL: begin
        case (tail)
          TAIL_SLL, TAIL_SRL, TAIL_SRA,
          TAIL_SLLV, TAIL_SRLV, TAIL_SRAV:   cls = CLS_SHIFT;
          TAIL_JR:                           cls = CLS_BRANCH;
          TAIL_JALR:                         cls = CLS_JUMPLINK;
          TAIL_MOVZ, TAIL_MOVN,
          TAIL_ADD, TAIL_ADDU, TAIL_SUB, TAIL_SUBU,
          TAIL_AND, TAIL_OR, TAIL_XOR, TAIL_NOR,
          TAIL_SLT, TAIL_SLTU:               cls = CLS_ALU;
          TAIL_SYSCALL:                      cls = CLS_SYSCALL;
          TAIL_MFHI, TAIL_MFLO: begin
            cls      = CLS_MDU;
            extra_wr = 1'b1;
          end
          TAIL_MTHI, TAIL_MTLO, TAIL_MULT, TAIL_MULTU,
          TAIL_DIV, TAIL_DIVU:               cls = CLS_MDU;
          default: ;
        endcase
      end
      OP_SPECIAL2: begin
        case (tail)
          TAIL_MUL: begin
            cls      = CLS_MDU;
            extra_wr = 1'b1;
          end
          TAIL_CLZ, TAIL_CLO: cls = CLS_ALU;
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: cls = CLS_BRANCH;
          RT_BLTZAL, RT_BGEZAL: begin
            cls      = CLS_JUMPLINK;
            regdst_o = REG_RA;
          end
          default: ;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_JAL: begin
        cls      = CLS_JUMPLINK;
        regdst_o = REG_RA;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        cls      = CLS_LOAD;
        regdst_o = rt;
      end
      OP_SB, OP_SH, OP_SW: cls = CLS_STORE;
      OP_COP0: begin
        if (rs == RS_MF) begin
          cls      = CLS_COP0;
          extra_wr = 1'b1;
          regdst_o = rt;
        end else if (rs == RS_MT) begin
          cls = CLS_COP0;
        end else if (rs[4]) begin
          // CO=1: TLB operations and ERET are selected by the function field
          case (tail)
            TAIL_TLBR, TAIL_TLBWI, TAIL_TLBWR, TAIL_TLBP: cls = CLS_COP0;
            TAIL_ERET: cls = CLS_ERET;
            default: ;
          endcase
        end
      end
      default: begin
        if (op[5:3] == 3'b001) begin
          cls      = CLS_ALU;
          regdst_o = rt;
        end
      end
    endcase
  end

  assign cls_o   = cls;
  assign regwr_o = extra_wr || (cls inside {CLS_ALU, CLS_SHIFT, CLS_LOAD, CLS_JUMPLINK});
`ifdef ID_RI_EXC_EN
  assign ri_o    = (cls == CLS_INVALID);
`endif

endmodule

// File: rtl/id_decode_queue.sv
// IF->ID decoupling FIFO with decode-on-write; holds a branch at the head until its delay slot is queued.
// ID_RI_EXC_EN adds the per-entry reserved-instruction bit and the id_ri_o port.
module id_decode_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             fetch_valid_i,
  output logic             fetch_ready_o,
  input  logic [31:0]      fetch_pc_i,
  input  logic [31:0]      fetch_instr_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_instr_o,
  output logic [3:0]       id_class_o,
  output logic             id_regwr_o,
  output logic [4:0]       id_regdst_o,
`ifdef ID_RI_EXC_EN
  output logic             id_ri_o,
`endif
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  id_entry_t         mem_q [DEPTH];
  id_entry_t         wr_entry, head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, not_empty, head_is_ctl;
  cls_e              pd_cls;
  logic              pd_regwr;
  logic [4:0]        pd_regdst;

  id_predecode u_predecode (
    .instr_i  (fetch_instr_i),
    .cls_o    (pd_cls),
    .regwr_o  (pd_regwr),
`ifdef ID_RI_EXC_EN
    .ri_o     (wr_entry.ri),
`endif
    .regdst_o (pd_regdst)
  );

  assign wr_entry.pc     = fetch_pc_i;
  assign wr_entry.instr  = fetch_instr_i;
  assign wr_entry.cls    = pd_cls;
  assign wr_entry.regwr  = pd_regwr;
  assign wr_entry.regdst = pd_regdst;

  assign fetch_ready_o = (count_q < CNT_W'(DEPTH));
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop           = id_valid_o && id_ready_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign not_empty   = (count_q != '0);
  assign head_is_ctl = (head.cls == CLS_BRANCH) || (head.cls == CLS_JUMPLINK);

  assign id_valid_o  = not_empty && !(head_is_ctl && (count_q < CNT_W'(2)));
  assign id_pc_o     = not_empty ? head.pc     : 32'd0;
  assign id_instr_o  = not_empty ? head.instr  : 32'd0;
  assign id_class_o  = not_empty ? head.cls    : 4'd0;
  assign id_regwr_o  = not_empty && head.regwr;
  assign id_regdst_o = not_empty ? head.regdst : 5'd0;
`ifdef ID_RI_EXC_EN
  assign id_ri_o     = id_valid_o && head.ri;
`endif
  assign count_o     = count_q;

endmodule

// File: tb/tb_id_decode_queue.sv
// Directed self-checking bench for id_decode_queue; ID_RI_EXC_EN enables the id_ri_o checks.
module tb_id_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] ADDIU = 32'h24220005;
  localparam logic [31:0] NOP   = 32'h00000000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             fetch_valid = 1'b0;
  logic             fetch_ready;
  logic [31:0]      fetch_pc = '0;
  logic [31:0]      fetch_instr = '0;
  logic             id_valid;
  logic             id_ready = 1'b0;
  logic [31:0]      id_pc, id_instr;
  logic [3:0]       id_class;
  logic             id_regwr;
  logic [4:0]       id_regdst;
  logic [CNT_W-1:0] count;
`ifdef ID_RI_EXC_EN
  logic             id_ri;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  id_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_pc_i    (fetch_pc),
    .fetch_instr_i (fetch_instr),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_instr_o    (id_instr),
    .id_class_o    (id_class),
    .id_regwr_o    (id_regwr),
    .id_regdst_o   (id_regdst),
`ifdef ID_RI_EXC_EN
    .id_ri_o       (id_ri),
`endif
    .count_o       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    fetch_instr = instr;
    tick();
    fetch_valid = 1'b0;
    $display("push pc=%h instr=%h count=%0d", pc, instr, count);
  endtask

  task automatic pop_one(input string tag, input logic [31:0] exp_pc);
    check(tag, id_pc, exp_pc);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    $display("pop  pc=%h count=%0d", exp_pc, count);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // decode table: instr, class, regwr, regdst, valid-when-alone
  localparam int NDEC = 13;
  logic [31:0] d_instr [NDEC];
  logic [3:0]  d_cls   [NDEC];
  logic        d_wr    [NDEC];
  logic [4:0]  d_dst   [NDEC];
  logic        d_vld   [NDEC];

  task automatic set_dec(input int i, input logic [31:0] ins, input logic [3:0] c,
                         input logic w, input logic [4:0] d, input logic v);
    d_instr[i] = ins; d_cls[i] = c; d_wr[i] = w; d_dst[i] = d; d_vld[i] = v;
  endtask

  initial begin
    set_dec(0,  32'h8C430004, 4'd2,  1'b1, 5'd3,  1'b1); // LW
    set_dec(1,  32'hAC430004, 4'd3,  1'b0, 5'd0,  1'b1); // SW
    set_dec(2,  32'h40026000, 4'd7,  1'b1, 5'd2,  1'b1); // MFC0
    set_dec(3,  32'h42000018, 4'd9,  1'b0, 5'd0,  1'b1); // ERET
    set_dec(4,  32'h0000000C, 4'd8,  1'b0, 5'd0,  1'b1); // SYSCALL
    set_dec(5,  32'h70431002, 4'd6,  1'b1, 5'd2,  1'b1); // MUL
    set_dec(6,  32'h00430018, 4'd6,  1'b0, 5'd0,  1'b1); // MULT
    set_dec(7,  32'h04510003, 4'd5,  1'b1, 5'd31, 1'b0); // BGEZAL
    set_dec(8,  32'h00851021, 4'd0,  1'b1, 5'd2,  1'b1); // ADDU
    set_dec(9,  32'h03E00008, 4'd4,  1'b0, 5'd0,  1'b0); // JR
    set_dec(10, 32'hFC000000, 4'd15, 1'b0, 5'd0,  1'b1); // reserved
    set_dec(11, 32'h00001010, 4'd6,  1'b1, 5'd2,  1'b1); // MFHI
    set_dec(12, 32'h00001040, 4'd1,  1'b1, 5'd2,  1'b1); // SLL rd=2

    // reset state
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_ready", 32'(fetch_ready), 32'd1);
    check("rst_pc", id_pc, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_class", 32'(id_class), 32'd0);
    check("rst_regwr", 32'(id_regwr), 32'd0);
    check("rst_regdst", 32'(id_regdst), 32'd0);
`ifdef ID_RI_EXC_EN
    check("rst_ri", 32'(id_ri), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // ADDIU single push, one-cycle latency
    push_one(32'h0, ADDIU);
    check("addiu_valid", 32'(id_valid), 32'd1);
    check("addiu_class", 32'(id_class), 32'd0);
    check("addiu_regwr", 32'(id_regwr), 32'd1);
    check("addiu_regdst", 32'(id_regdst), 32'd2);
    check("addiu_count", 32'(count), 32'd1);
    check("addiu_instr", id_instr, ADDIU);
    pop_one("addiu_pc", 32'h0);
    check("addiu_empty", 32'(id_valid), 32'd0);

    // BEQ held until delay slot is resident
    push_one(32'h100, 32'h10220003);
    check("beq_hold_valid", 32'(id_valid), 32'd0);
    check("beq_hold_count", 32'(count), 32'd1);
    check("beq_class", 32'(id_class), 32'd4);
    push_one(32'h104, NOP);
    check("beq_rel_valid", 32'(id_valid), 32'd1);
    check("beq_rel_pc", id_pc, 32'h100);
    id_ready = 1'b1;
    tick();
    check("slot_pc", id_pc, 32'h104);
    check("slot_class", 32'(id_class), 32'd1);
    check("slot_valid", 32'(id_valid), 32'd1);
    tick();
    id_ready = 1'b0;
    check("slot_done_count", 32'(count), 32'd0);
    check("slot_done_valid", 32'(id_valid), 32'd0);

    // fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) push_one(32'h200 + 32'(4 * i), ADDIU);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(fetch_ready), 32'd0);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h210;
    fetch_instr = ADDIU;
    tick();
    check("full_blocked_count", 32'(count), 32'd4);
    check("full_blocked_head", id_pc, 32'h200);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ready", 32'(fetch_ready), 32'd1);
    tick();
    fetch_valid = 1'b0;
    check("fifth_count", 32'(count), 32'd4);
    for (int i = 1; i <= DEPTH; i++) pop_one("drain_pc", 32'h200 + 32'(4 * i));
    check("drain_count", 32'(count), 32'd0);

    // concurrent push/pop at count 2 across 10 wraps
    push_one(32'h300, ADDIU);
    push_one(32'h304, ADDIU);
    for (int k = 0; k < 10 * DEPTH; k++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h308 + 32'(4 * k);
      fetch_instr = ADDIU;
      id_ready    = 1'b1;
      check("wrap_order", id_pc, 32'h300 + 32'(4 * k));
      tick();
      check("wrap_count", 32'(count), 32'd2);
    end
    fetch_valid = 1'b0;
    id_ready    = 1'b0;
    pop_one("wrap_tail0", 32'h300 + 32'(4 * 10 * DEPTH));
    pop_one("wrap_tail1", 32'h304 + 32'(4 * 10 * DEPTH));

    // flush beats a simultaneous push
    for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(4 * i), ADDIU);
    check("preflush_count", 32'(count), 32'd3);
    fetch_valid = 1'b1;
    fetch_pc    = 32'hDEAD0;
    fetch_instr = ADDIU;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_ready", 32'(fetch_ready), 32'd1);
    push_one(32'h600, ADDIU);
    check("postflush_pc", id_pc, 32'h600);
    check("postflush_count", 32'(count), 32'd1);
    do_flush();

    // JAL plus slot
    push_one(32'h700, 32'h0C000010);
    check("jal_hold", 32'(id_valid), 32'd0);
    push_one(32'h704, NOP);
    check("jal_valid", 32'(id_valid), 32'd1);
    check("jal_class", 32'(id_class), 32'd5);
    check("jal_regdst", 32'(id_regdst), 32'd31);
    check("jal_regwr", 32'(id_regwr), 32'd1);
    pop_one("jal_pc", 32'h700);
    pop_one("jal_slot_pc", 32'h704);

    // decode table, one entry at a time
    for (int i = 0; i < NDEC; i++) begin
      push_one(32'h800 + 32'(4 * i), d_instr[i]);
      check("dec_class", 32'(id_class), 32'(d_cls[i]));
      check("dec_regwr", 32'(id_regwr), 32'(d_wr[i]));
      check("dec_regdst", 32'(id_regdst), 32'(d_dst[i]));
      check("dec_valid", 32'(id_valid), 32'(d_vld[i]));
`ifdef ID_RI_EXC_EN
      check("dec_ri", 32'(id_ri), 32'(d_vld[i] && (d_cls[i] == 4'd15)));
`endif
      do_flush();
    end

    // asynchronous reset mid-operation
    push_one(32'h900, ADDIU);
    push_one(32'h904, ADDIU);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(id_valid), 32'd0);
    check("async_rst_pc", id_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_ready", 32'(fetch_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
